// File: rtl/cci_mpf_prim_lutram_rmw_counter_if.sv
// Update/response/query bundle for the LUTRAM read-modify-write counter array.
// The master drives requests and queries; the slave (the counter engine) drives results.
interface cci_mpf_prim_lutram_rmw_counter_if #(
  parameter int N_ENTRIES  = 32,
  parameter int N_CNT_BITS = 8
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic                  rdy;
  logic                  upd_en;
  logic [IDX_W-1:0]      upd_idx;
  logic                  upd_dec;
  logic                  upd_rsp_valid;
  logic [IDX_W-1:0]      upd_rsp_idx;
  logic [N_CNT_BITS-1:0] upd_rsp_value;
  logic                  upd_rsp_ovf;
  logic [IDX_W-1:0]      rd_idx;
  logic [N_CNT_BITS-1:0] rd_value;

  modport master (
    input  rdy,
    input  upd_rsp_valid,
    input  upd_rsp_idx,
    input  upd_rsp_value,
    input  upd_rsp_ovf,
    input  rd_value,
    output upd_en,
    output upd_idx,
    output upd_dec,
    output rd_idx
  );

  modport slave (
    output rdy,
    output upd_rsp_valid,
    output upd_rsp_idx,
    output upd_rsp_value,
    output upd_rsp_ovf,
    output rd_value,
    input  upd_en,
    input  upd_idx,
    input  upd_dec,
    input  rd_idx
  );
endinterface

// File: rtl/cci_mpf_prim_lutram_rmw_counter.sv
// Two-stage read-modify-write engine over a LUTRAM array of counters, with a
// same-index bypass so back-to-back updates to one counter are always cumulative.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | sweeping the array, writing 0 to index init_ptr each cycle
// ST_RUN  | array initialised; rdy=1, updates and queries accepted
module cci_mpf_prim_lutram_rmw_counter #(
  parameter int N_ENTRIES  = 32,
  parameter int N_CNT_BITS = 8,
  parameter int SATURATE   = 1
) (
  input  logic clk,
  input  logic reset,
  cci_mpf_prim_lutram_rmw_counter_if.slave bus
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [N_CNT_BITS-1:0] cnt_t;

  localparam idx_t LAST_IDX = idx_t'(N_ENTRIES - 1);
  localparam cnt_t CNT_MAX  = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_nxt;
  idx_t   init_ptr;
  idx_t   init_ptr_nxt;
  logic   init_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    init_we      = 1'b0;
    case (state)
      ST_INIT: begin
        init_we      = 1'b1;
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == LAST_IDX) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  logic rdy;
  assign rdy     = (state == ST_RUN);
  assign bus.rdy = rdy;

  // Counter storage; contents are meaningless until the init sweep finishes.
  cnt_t mem [N_ENTRIES];

  logic t1_valid;
  idx_t t1_idx;
  logic t1_dec;
  cnt_t t1_old;
  cnt_t t1_new;
  logic t1_ovf;

  logic t0_fire;
  cnt_t t0_old;

  assign t0_fire = rdy & bus.upd_en;

  // The T1 write has not landed yet, so a matching T0 read takes T1's result.
  always_comb begin
    if (t1_valid && (t1_idx == bus.upd_idx)) begin
      t0_old = t1_new;
    end else begin
      t0_old = mem[bus.upd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t1_valid <= 1'b0;
      t1_idx   <= '0;
      t1_dec   <= 1'b0;
      t1_old   <= '0;
    end else begin
      t1_valid <= t0_fire;
      t1_idx   <= bus.upd_idx;
      t1_dec   <= bus.upd_dec;
      t1_old   <= t0_old;
    end
  end

  always_comb begin
    t1_new = t1_old;
    t1_ovf = 1'b0;
    if (t1_dec) begin
      if (t1_old == '0) begin
        t1_ovf = 1'b1;
        t1_new = (SATURATE != 0) ? cnt_t'(0) : CNT_MAX;
      end else begin
        t1_new = t1_old - 1'b1;
      end
    end else begin
      if (t1_old == CNT_MAX) begin
        t1_ovf = 1'b1;
        t1_new = (SATURATE != 0) ? CNT_MAX : cnt_t'(0);
      end else begin
        t1_new = t1_old + 1'b1;
      end
    end
  end

  logic wr_en;
  idx_t wr_idx;
  cnt_t wr_data;

  // The sweep and the update pipeline never overlap: updates need rdy=1.
  always_comb begin
    wr_en   = init_we | t1_valid;
    wr_idx  = init_we ? init_ptr : t1_idx;
    wr_data = init_we ? cnt_t'(0) : t1_new;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  logic rsp_valid;
  idx_t rsp_idx;
  cnt_t rsp_value;
  logic rsp_ovf;
  cnt_t rd_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_idx   <= '0;
      rsp_value <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      rsp_valid <= t1_valid;
      if (t1_valid) begin
        rsp_idx   <= t1_idx;
        rsp_value <= t1_new;
        rsp_ovf   <= t1_ovf;
      end
    end
  end

  // Query sees every update older than this cycle, including the one still in T1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_value <= '0;
    end else if (t1_valid && (t1_idx == bus.rd_idx)) begin
      rd_value <= t1_new;
    end else begin
      rd_value <= mem[bus.rd_idx];
    end
  end

  assign bus.upd_rsp_valid = rsp_valid;
  assign bus.upd_rsp_idx   = rsp_idx;
  assign bus.upd_rsp_value = rsp_value;
  assign bus.upd_rsp_ovf   = rsp_ovf;
  assign bus.rd_value      = rd_value;
endmodule

// File: tb/tb_cci_mpf_prim_lutram_rmw_counter.sv
// Three counter engines (8-bit saturating, 2-bit saturating, 2-bit wrapping) share
// one stimulus stream; each is scored against an arithmetic reference model.
module tb_cci_mpf_prim_lutram_rmw_counter;
  localparam int N     = 32;
  localparam int N_DUT = 3;

  typedef struct {
    int idx;
    int val;
    bit ovf;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd_en;
  logic [4:0] upd_idx;
  logic       upd_dec;
  logic [4:0] rd_idx;

  logic [N_DUT-1:0] rdy_v;
  logic [N_DUT-1:0] rsp_valid_v;
  logic [N_DUT-1:0] rsp_ovf_v;
  logic [4:0]       rsp_idx_v   [N_DUT];
  logic [7:0]       rsp_value_v [N_DUT];
  logic [7:0]       rd_value_v  [N_DUT];

  always #5 clk = ~clk;

  function automatic int bits_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic bit sat_of(input int i);
    return (i != 2);
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int B = (g == 0) ? 8 : 2;
    localparam int S = (g == 2) ? 0 : 1;

    cci_mpf_prim_lutram_rmw_counter_if #(.N_ENTRIES(N), .N_CNT_BITS(B)) bus ();

    assign bus.upd_en  = upd_en;
    assign bus.upd_idx = upd_idx;
    assign bus.upd_dec = upd_dec;
    assign bus.rd_idx  = rd_idx;

    cci_mpf_prim_lutram_rmw_counter #(
      .N_ENTRIES (N),
      .N_CNT_BITS(B),
      .SATURATE  (S)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );

    assign rdy_v[g]       = bus.rdy;
    assign rsp_valid_v[g] = bus.upd_rsp_valid;
    assign rsp_ovf_v[g]   = bus.upd_rsp_ovf;
    assign rsp_idx_v[g]   = bus.upd_rsp_idx;
    assign rsp_value_v[g] = 8'(bus.upd_rsp_value);
    assign rd_value_v[g]  = 8'(bus.rd_value);
  end

  // Reference model: counter values as plain integers, advanced in request order.
  int   mdl    [N_DUT][N];
  exp_t q      [N_DUT][$];
  int   rd_exp [N_DUT];
  bit   rd_pend;
  int   rel_cnt;
  int   cyc;
  bit   done;

  always @(posedge clk or posedge reset) begin
    int  v, mx, nv;
    bit  ov, ready;
    exp_t e;
    if (reset) begin
      rel_cnt = 0;
      rd_pend = 1'b0;
      for (int i = 0; i < N_DUT; i++) begin
        q[i].delete();
        for (int k = 0; k < N; k++) mdl[i][k] = 0;
      end
    end else begin
      ready   = (rel_cnt >= N);
      rd_pend = ready;
      for (int i = 0; i < N_DUT; i++) begin
        rd_exp[i] = mdl[i][rd_idx];
        if (ready && upd_en) begin
          v  = mdl[i][upd_idx];
          mx = (1 << bits_of(i)) - 1;
          ov = 1'b0;
          if (upd_dec) begin
            if (v == 0) begin
              ov = 1'b1;
              nv = sat_of(i) ? 0 : mx;
            end else nv = v - 1;
          end else begin
            if (v == mx) begin
              ov = 1'b1;
              nv = sat_of(i) ? mx : 0;
            end else nv = v + 1;
          end
          mdl[i][upd_idx] = nv;
          e.idx = int'(upd_idx);
          e.val = nv;
          e.ovf = ov;
          e.cyc = cyc;
          q[i].push_back(e);
        end
      end
      if (rel_cnt < N) rel_cnt++;
      cyc++;
    end
  end

  int checks;
  int errors;

  always begin
    exp_t e;
    @(negedge clk or posedge reset);
    #1;
    if (reset) begin
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (rdy_v[i] || rsp_valid_v[i] || rsp_ovf_v[i] || rsp_idx_v[i] != 0 ||
            rsp_value_v[i] != 0 || rd_value_v[i] != 0) begin
          errors++;
          $display("FAIL reset_vals dut%0d: rdy=%0b vld=%0b idx=%0d val=%0d ovf=%0b rd=%0d, want all 0",
                   i, rdy_v[i], rsp_valid_v[i], rsp_idx_v[i], rsp_value_v[i], rsp_ovf_v[i], rd_value_v[i]);
        end
      end
    end else begin
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (rdy_v[i] != (rel_cnt >= N)) begin
          errors++;
          $display("FAIL rdy dut%0d cyc=%0d: got %0b want %0b", i, rel_cnt, rdy_v[i], rel_cnt >= N);
        end
        if (rsp_valid_v[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp dut%0d: got idx=%0d val=%0d, want no response",
                     i, rsp_idx_v[i], rsp_value_v[i]);
          end else begin
            e = q[i].pop_front();
            if (int'(rsp_idx_v[i]) != e.idx || int'(rsp_value_v[i]) != e.val ||
                rsp_ovf_v[i] != e.ovf || cyc != e.cyc + 2) begin
              errors++;
              $display("FAIL rsp dut%0d: got idx=%0d val=%0d ovf=%0b cyc=%0d want idx=%0d val=%0d ovf=%0b cyc=%0d",
                       i, rsp_idx_v[i], rsp_value_v[i], rsp_ovf_v[i], cyc, e.idx, e.val, e.ovf, e.cyc + 2);
            end
          end
        end else if (q[i].size() != 0 && q[i][0].cyc + 2 <= cyc) begin
          checks++;
          errors++;
          e = q[i].pop_front();
          $display("FAIL missing_rsp dut%0d: got none at cyc=%0d want idx=%0d val=%0d", i, cyc, e.idx, e.val);
        end
        if (rd_pend) begin
          checks++;
          if (int'(rd_value_v[i]) != rd_exp[i]) begin
            errors++;
            $display("FAIL rd_value dut%0d: got %0d want %0d", i, rd_value_v[i], rd_exp[i]);
          end
        end
      end
      if (done || cyc > 60000) begin
        for (int i = 0; i < N_DUT; i++) begin
          checks++;
          if (q[i].size() != 0 || !done) begin
            errors++;
            $display("FAIL drain dut%0d: got %0d outstanding done=%0b want 0 outstanding done=1",
                     i, q[i].size(), done);
          end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic drive(input bit en, input int idx, input bit dec, input int ridx);
    upd_en  = en;
    upd_idx = 5'(idx);
    upd_dec = dec;
    rd_idx  = 5'(ridx);
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n, input bit en_all);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, N - 1));
      drive(en_all || ($urandom_range(0, 3) != 0), idx, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? idx : int'($urandom_range(0, N - 1)));
    end
  endtask

  task automatic sweep_reads();
    for (int k = 0; k < N; k++) drive(1'b0, 0, 1'b0, k);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    done    = 1'b0;
    reset   = 1'b1;
    upd_en  = 1'b0;
    upd_idx = '0;
    upd_dec = 1'b0;
    rd_idx  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Requests during the init sweep must be ignored.
    rand_cycles(N, 1'b1);
    sweep_reads();

    drive(1'b1, 5, 1'b0, 5);
    drive(1'b0, 0, 1'b0, 5);
    drive(1'b0, 0, 1'b0, 5);
    drive(1'b0, 0, 1'b0, 5);

    repeat (4) drive(1'b1, 7, 1'b0, 7);
    drive(1'b1, 7, 1'b1, 7);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 7, 1'b0, 8);
      drive(1'b1, 8, 1'b0, 7);
    end

    repeat (4) drive(1'b1, 3, 1'b0, 3);
    drive(1'b1, 3, 1'b1, 3);
    repeat (5) drive(1'b1, 9, 1'b0, 9);
    drive(1'b1, 4, 1'b1, 4);

    repeat (258) drive(1'b1, 20, 1'b0, 20);
    repeat (260) drive(1'b1, 20, 1'b1, 20);
    repeat (3) drive(1'b0, 0, 1'b0, 20);

    rand_cycles(3000, 1'b0);

    // Reset lands with one update in T1 and another being presented.
    drive(1'b1, 12, 1'b0, 12);
    upd_en  = 1'b1;
    upd_idx = 5'd12;
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rand_cycles(N, 1'b1);
    sweep_reads();
    rand_cycles(300, 1'b0);
    repeat (4) drive(1'b0, 0, 1'b0, 0);
    done = 1'b1;
    repeat (4) @(negedge clk);
  end
endmodule
